// File: rtl/cordic_phase_meter.sv
// cordic_phase_meter: iterative vectoring-mode CORDIC phase/frequency/magnitude meter.
// Takes one complex sample (cos = I, sin = Q) per handshake and returns its phase in
// DDS turn scaling (2^PW = one turn). It also returns the phase step since the last
// nonzero sample and the magnitude, which still carries the CORDIC gain.
module cordic_phase_meter #(
  parameter int PW   = 32,
  parameter int DW   = 10,
  parameter int ITER = 16,
  parameter int GB   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] cos,
  input  logic signed [DW-1:0] sin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        phase,
  output logic [PW-1:0]        freq,
  output logic [DW:0]          mag
);

  localparam int  XW = DW + 2 + GB;
  localparam int  IW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic signed [XW-1:0] x, y;
  logic        [PW-1:0] z;
  logic        [IW-1:0] i;
  logic                 zero;
  logic                 first_flag;
  logic        [PW-1:0] prev_phase;

  // Arctangent table in turns, resolved at elaboration.
  logic [PW-1:0] atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam real ANG = $atan(2.0 ** (-g)) / (2.0 * PI) * (2.0 ** PW);
    assign atan_tab[g] = PW'(longint'(ANG));
  end

  // Inputs widened with guard bits. The extra integer bits absorb both the
  // negation of -2^(DW-1) and the CORDIC gain.
  logic signed [XW-1:0] cos_x, sin_x;
  assign cos_x = XW'(cos) <<< GB;
  assign sin_x = XW'(sin) <<< GB;

  // One micro-rotation. It rotates toward the +X axis, and both updates use the old X/Y values.
  logic signed [XW-1:0] xs, ys, xn, yn;
  logic        [PW-1:0] zn;
  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    if (!y[XW-1]) begin
      xn = x + ys;
      yn = y - xs;
      zn = z + atan_tab[i];
    end else begin
      xn = x - ys;
      yn = y + xs;
      zn = z - atan_tab[i];
    end
  end

  assign in_ready = (state == IDLE);

  // Control FSM, CORDIC datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      phase      <= '0;
      freq       <= '0;
      mag        <= '0;
      prev_phase <= '0;
      first_flag <= 1'b1;
      zero       <= 1'b0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      i          <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          zero  <= (cos == '0) && (sin == '0);
          i     <= '0;
          state <= RUN;
          // Pre-rotate into the right half plane so the CORDIC range (+-99.9 deg) suffices.
          if (!cos[DW-1]) begin
            x <= cos_x;
            y <= sin_x;
            z <= '0;
          end else if (!sin[DW-1]) begin
            x <= sin_x;
            y <= -cos_x;
            z <= {2'b01, {(PW-2){1'b0}}};
          end else begin
            x <= -sin_x;
            y <= cos_x;
            z <= {2'b11, {(PW-2){1'b0}}};
          end
        end
        RUN: begin
          x <= xn;
          y <= yn;
          z <= zn;
          i <= i + 1'b1;
          if (i == IW'(ITER - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (zero) begin
              // A zero vector has no phase. Report zeros and keep the frequency reference.
              phase <= '0;
              freq  <= '0;
              mag   <= '0;
            end else begin
              phase      <= zn;
              mag        <= xn[XW-1] ? '0 : xn[GB +: DW+1];
              freq       <= first_flag ? '0 : zn - prev_phase;
              prev_phase <= zn;
              first_flag <= 1'b0;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_phase_meter.sv
// Directed bench for cordic_phase_meter: table of cardinal/extreme vectors plus
// hand-written sequences for wrap, streaming, backpressure, zero and async reset.
module tb_cordic_phase_meter;
  localparam int PW = 32, DW = 10, ITER = 16;

  logic                 clk = 1'b0, rst = 1'b0;
  logic                 in_valid = 1'b0, out_ready = 1'b1;
  logic                 in_ready, out_valid;
  logic signed [DW-1:0] cos_i = '0, sin_i = '0;
  logic [PW-1:0]        phase, freq;
  logic [DW:0]          mag;

  int errs = 0, checks = 0, cyc = 0;

  cordic_phase_meter #(.PW(PW), .DW(DW), .ITER(ITER), .GB(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cos(cos_i), .sin(sin_i), .out_valid(out_valid), .out_ready(out_ready),
    .phase(phase), .freq(freq), .mag(mag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running (want finished)");
    $fatal(1, "watchdog");
  end

  // Compare modulo 2^32 within +-tol.
  task automatic chk(input string name, input logic [31:0] act, exp, input longint tol);
    logic signed [31:0] sd;
    longint d;
    sd = act - exp;
    d  = (sd < 0) ? -longint'(sd) : longint'(sd);
    checks++;
    if (d > tol) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (tol %0h)", name, act, exp, tol);
    end
  endtask

  function automatic void mk(input logic [31:0] a, input real amp, output int c, s);
    real th;
    th = 2.0 * 3.141592653589793 * real'(a) / 4294967296.0;
    c  = int'(amp * $cos(th));
    s  = int'(amp * $sin(th));
  endfunction

  task automatic send(input int c, s);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errs++;
      $display("FAIL send_timeout: in_ready=0 want 1");
    end
    cos_i = DW'(c); sin_i = DW'(s); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [PW-1:0] ph, fr, output logic [DW:0] mg, output int tc);
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; errs++;
      $display("FAIL recv_timeout: out_valid=0 want 1");
    end
    ph = phase; fr = freq; mg = mag; tc = cyc;
    if (out_ready) @(negedge clk);
  endtask

  task automatic sample(input int c, s, output logic [PW-1:0] ph, fr, output logic [DW:0] mg, output int tc);
    send(c, s);
    recv(ph, fr, mg, tc);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    int          c, s;
    logic [31:0] ph;
    longint      ptol;
    int          mg, mtol;
  } vec_t;

  initial begin
    vec_t          tv[6];
    logic [PW-1:0] ph, fr, ph0, fr0;
    logic [DW:0]   mg, mg0;
    int            tc, tprev, c, s, bad;

    tv[0] = '{511,  0,    32'h00000000, 64'd1 << 22, 841,  2};
    tv[1] = '{0,    511,  32'h40000000, 64'd1 << 22, 841,  2};
    tv[2] = '{-511, 0,    32'h80000000, 64'd1 << 22, 841,  2};
    tv[3] = '{0,    -511, 32'hC0000000, 64'd1 << 22, 841,  2};
    tv[4] = '{-512, -512, 32'hA0000000, 64'd1 << 22, 1192, 4};
    tv[5] = '{511,  511,  32'h20000000, 64'd1 << 22, 1190, 4};

    // Asynchronous reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1, 0);
    chk("rst_out_valid", 32'(out_valid), 32'd0, 0);
    chk("rst_phase", phase, 32'd0, 0);
    chk("rst_freq", freq, 32'd0, 0);
    chk("rst_mag", 32'(mag), 32'd0, 0);
    rst = 1'b0;

    // Table-driven vectors
    for (int k = 0; k < 6; k++) begin
      sample(tv[k].c, tv[k].s, ph, fr, mg, tc);
      chk($sformatf("vec%0d_phase", k), ph, tv[k].ph, tv[k].ptol);
      chk($sformatf("vec%0d_mag", k), 32'(mg), 32'(tv[k].mg), longint'(tv[k].mtol));
      if (k == 0) chk("vec0_first_freq", fr, 32'd0, 0);
    end

    // Wrap across 0 degrees, both directions
    mk(32'hF0000000, 500.0, c, s); sample(c, s, ph, fr, mg, tc);
    mk(32'h10000000, 500.0, c, s); sample(c, s, ph, fr, mg, tc);
    chk("wrap_fwd_freq", fr, 32'h20000000, 64'd1 << 23);
    mk(32'hF0000000, 500.0, c, s); sample(c, s, ph, fr, mg, tc);
    chk("wrap_rev_freq", fr, 32'hE0000000, 64'd1 << 23);

    // Zero sample keeps the frequency reference
    mk(32'h10000000, 500.0, c, s); sample(c, s, ph, fr, mg, tc);
    sample(0, 0, ph, fr, mg, tc);
    chk("zero_phase", ph, 32'd0, 0);
    chk("zero_mag", 32'(mg), 32'd0, 0);
    chk("zero_freq", fr, 32'd0, 0);
    mk(32'h30000000, 500.0, c, s); sample(c, s, ph, fr, mg, tc);
    chk("after_zero_freq", fr, 32'h20000000, 64'd1 << 23);

    // Stream from reset: first freq 0, then constant step, 18-cycle period
    do_reset();
    tprev = 0;
    for (int k = 0; k < 64; k++) begin
      mk(32'(k) * 32'h01000000, 500.0, c, s);
      sample(c, s, ph, fr, mg, tc);
      if (k == 0) chk("stream_first_freq", fr, 32'd0, 0);
      else begin
        chk($sformatf("stream%0d_freq", k), fr, 32'h01000000, 64'd1 << 23);
        chk($sformatf("stream%0d_period", k), 32'(tc - tprev), 32'd18, 0);
      end
      tprev = tc;
    end

    // Backpressure: outputs hold, new input ignored, in_ready returns after handshake
    out_ready = 1'b0;
    mk(32'h50000000, 500.0, c, s);
    send(c, s);
    recv(ph0, fr0, mg0, tc);
    chk("bp_phase", ph0, 32'h50000000, 64'd1 << 22);
    chk("bp_freq", fr0, 32'h11000000, 64'd1 << 23);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin cos_i = -10'sd300; sin_i = 10'sd100; in_valid = 1'b1; end
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1, 0);
      chk($sformatf("bp%0d_ready", k), 32'(in_ready), 32'd0, 0);
      chk($sformatf("bp%0d_phase", k), phase, ph0, 0);
      chk($sformatf("bp%0d_freq", k), freq, fr0, 0);
      chk($sformatf("bp%0d_mag", k), 32'(mag), 32'(mg0), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0, 0);
    chk("bp_release_ready", 32'(in_ready), 32'd1, 0);
    repeat (3) @(negedge clk);
    chk("bp_ignored_sample", 32'(in_ready), 32'd1, 0);

    // Async reset at RUN iteration 5
    mk(32'h70000000, 500.0, c, s);
    send(c, s);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0, 0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1, 0);
    chk("midrst_phase", phase, 32'd0, 0);
    chk("midrst_freq", freq, 32'd0, 0);
    chk("midrst_mag", 32'(mag), 32'd0, 0);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (25) begin @(negedge clk); if (out_valid) bad++; end
    chk("midrst_no_output", 32'(bad), 32'd0, 0);
    mk(32'h20000000, 500.0, c, s); sample(c, s, ph, fr, mg, tc);
    chk("postrst_phase", ph, 32'h20000000, 64'd1 << 22);
    chk("postrst_freq", fr, 32'd0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cordic_phase_meter.md
# cordic_phase_meter

- Receive-side counterpart of the DDS/OrthDDS generators in the ADPLL path.
- Accepts one complex sample per handshake (cos = I, sin = Q, signed) and recovers its instantaneous phase as a PW-bit phase word in the same turn scaling as the DDS phase accumulator (2^PW = one turn).
- Also outputs the frequency word (phase step since the previous sample) and the uncompensated magnitude, using an iterative CORDIC in vectoring mode.
- Feeds the ADPLL phase detector and loop filter.

## Interface

Parameters:
- PW, 32: phase/frequency word width; 2^PW = 360°.
- DW, 10: input sample width, signed.
- ITER, 16: CORDIC micro-rotations; 1 ≤ ITER ≤ PW-2.
- GB, 4: fractional guard bits on the internal X/Y datapath.

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block can accept a sample; high only in IDLE.
- cos, in, DW signed: in-phase component.
- sin, in, DW signed: quadrature component.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- phase, out, PW unsigned: atan2(sin, cos) in turns, modulo 2^PW.
- freq, out, PW signed: phase minus previous accepted nonzero sample's phase, modulo 2^PW.
- mag, out, DW+1 unsigned: ≈1.6468·sqrt(cos²+sin²), truncated.

## Operation

- Internal X/Y registers are signed, DW+2+GB bits. Inputs are sign-extended and shifted left by GB. Z is PW bits and wraps modulo 2^PW.
- Angle table: entry i = round(atan(2^-i)/(2π)·2^PW), for i = 0..ITER-1. Computed at elaboration with $atan.
- FSM states: IDLE, RUN, DONE.
- **IDLE:** in_ready=1. On in_valid, capture the sample with pre-rotation, clear iteration counter i, go to RUN.
  - cos ≥ 0: X=cos, Y=sin, Z=0.
  - cos < 0, sin ≥ 0: X=sin, Y=-cos, Z=0x4000…0 (+90°).
  - cos < 0, sin < 0: X=-sin, Y=cos, Z=0xC000…0 (-90°).
  - cos = -2^(DW-1) must negate without overflow.
- **RUN:** one micro-rotation per cycle, all using old values of X, Y.
  - Y ≥ 0: X+=Y>>>i, Y-=X>>>i, Z+=atan_i.
  - Y < 0: X-=Y>>>i, Y+=X>>>i, Z-=atan_i.
  - After the iteration with i=ITER-1, go to DONE.
- **Entering DONE:** register the results.
  - phase=Z.
  - mag=X>>>GB, truncated toward zero.
  - freq=Z-prev_phase, two's-complement wrap, interpreted signed.
  - Then set prev_phase=Z.
- **Zero input (cos=sin=0):** phase=0, mag=0, freq=0, prev_phase unchanged.
- **First nonzero sample after reset:** freq=0; this sample seeds prev_phase. A first_flag, set by reset, tracks this.
- **DONE:** out_valid=1. phase, freq and mag hold stable until out_valid && out_ready, then go to IDLE.
- **Reset:** asynchronous. Applies immediately, including mid-RUN or in DONE.
  - state=IDLE; out_valid=0; phase=0; freq=0; mag=0; prev_phase=0; first_flag=1.
  - An in-flight sample is discarded.
  - in_ready is 1 once in IDLE.

## Timing

- Input accepted on edge t (in_valid && in_ready).
- RUN occupies edges t+1 .. t+ITER.
- out_valid rises after edge t+ITER (ITER+1 cycles of latency).
- in_ready is low from edge t until the output handshake edge, and returns high the cycle after it.
- Minimum sample period: ITER+2 cycles (18 at defaults) with out_ready held high.
- out_valid never drops without a handshake except on reset.
- in_valid while in_ready=0 is ignored; the upstream holds the sample.
- Accuracy at defaults: |phase error| ≤ 2^(PW-DW) LSB (≈0.35°) for |input| ≥ 2^(DW-2).

## Test plan

- **Cardinal angles:** for (cos,sin) in (511,0), (0,511), (-511,0), (0,-511) → phase within ±2^22 of 0x00000000, 0x40000000, 0x80000000, 0xC0000000 respectively. For (511,0), mag = 841±2.
- **Wrap across 0°:** feed angles 0xF0000000 then 0x10000000, at amplitude 500, from an exact sine table → second result freq = +0x20000000 ±2^23. Feed the reverse order → freq = -0x20000000 ±2^23.
- **Stream and first sample:** 64 samples stepping 0x01000000 per sample from reset → first result freq=0, all others 0x01000000 ±2^23. With out_ready=1, out_valid pulses exactly every 18 cycles.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Release → handshake, then in_ready=1 on the next cycle.
- **Zero and extremes:** (0,0) → phase=0, mag=0, freq=0, and the next sample's freq is relative to the sample before the zero. (-512,-512) → phase ≈ 0xA0000000 with no overflow, mag ≈ 1192.
- **Reset mid-operation:** assert rst at RUN iteration 5 → all outputs are 0 asynchronously, no out_valid for that sample. The next sample after reset reports freq=0.
